// File: rtl/arb_pkg.sv
// Shared types, constants and the rotating-priority search for the
// four-requester round-robin arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  // Rotating priority search: scans ptr, ptr+1, ... (mod NUM_REQ) and
  // returns {found, index} of the first set request bit.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0]   r;
    logic [IDX_W-1:0] k;
    r = '0;
    // Walk from the lowest priority upward so the highest-priority hit is
    // the last one written.
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      k = ptr + IDX_W'(i);
      if (req[k]) r = {1'b1, k};
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_rr4_ctrl_grant_dec.sv
// 2-to-4 index-to-one-hot decode with enable; purely combinational.
module grant_dec_2to4
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]   i_idx,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt
);

  // One-hot decode, all zero when disabled.
  always_comb begin
    o_gnt = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (i_en && (i_idx == IDX_W'(k))) o_gnt[k] = 1'b1;
  end

endmodule

// File: rtl/arb_rr4_ctrl.sv
// Four-requester round-robin arbiter. The owner index and busy flag are
// registered; gnt is their one-hot decode, so it can never be multi-hot.
// Optional feature: define ARB_TIMEOUT_EN to revoke a grant held for
// MAX_HOLD cycles while another agent waits.
module arb_rr4_ctrl
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               busy,
  output logic               timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("arb_rr4_ctrl: MAX_HOLD must be within 2..256");
  end

  arb_state_e         r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_ptr;
  logic               r_busy;

  logic               w_own;
  logic               w_expire;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [NUM_REQ-1:0] w_others;
  logic [IDX_W:0]     w_pick_idle;
  logic [IDX_W:0]     w_pick_hand;

  assign w_own       = req[r_idx];
  assign w_ptr_nxt   = r_idx + IDX_W'(1);
  assign w_others    = req & ~(NUM_REQ'(1) << r_idx);
  assign w_pick_idle = rr_pick(req, r_ptr);
  // Handover search starts after the outgoing owner and excludes it, so a
  // revoked owner still holding req goes to the back of the rotation.
  assign w_pick_hand = rr_pick(w_others, w_ptr_nxt);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  assign w_expire = w_own && (r_cnt == CNT_LAST) && (|w_others);
  assign timeout  = r_timeout;
`else
  assign w_expire = 1'b0;
  assign timeout  = 1'b0;
`endif

  // Arbitration FSM: grant from IDLE, hold while the owner requests,
  // hand over or go idle on release (or on hold expiry).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_busy    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      if (r_state == ARB_IDLE) begin
        if (w_pick_idle[IDX_W]) begin
          r_state <= ARB_GRANT;
          r_idx   <= w_pick_idle[IDX_W-1:0];
          r_busy  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
      end else begin
        if (!w_own || w_expire) begin
          r_ptr <= w_ptr_nxt;
`ifdef ARB_TIMEOUT_EN
          r_cnt <= '0;
`endif
          if (w_pick_hand[IDX_W]) begin
            r_idx <= w_pick_hand[IDX_W-1:0];
`ifdef ARB_TIMEOUT_EN
            r_timeout <= w_expire;
`endif
          end else begin
            r_state <= ARB_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_cnt != CNT_LAST) begin
          // Saturates at the last count when nobody else is waiting.
          r_cnt <= r_cnt + CNT_W'(1);
        end
`endif
      end
    end
  end

  grant_dec_2to4 u_dec (
    .i_idx (r_idx),
    .i_en  (r_busy),
    .o_gnt (gnt)
  );

  assign gnt_idx = r_idx;
  assign busy    = r_busy;

endmodule
